// File: rtl/fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// fifo_rr_sched
//
// Round-robin read scheduler. Drains NUM_Q independent FIFOs into a single
// valid/ready output stream. Each grant reads up to BURST_MAX consecutive words
// from one queue. After that the search pointer moves past that queue, so every
// non-empty queue is served within NUM_Q-1 other grants.
//
// Per word the FSM walks ISSUE -> LOAD -> OUT:
//   ISSUE : pulse q_renable[grant] for one cycle.
//   LOAD  : the queue's registered rdata is now valid; capture it.
//   OUT   : hold out_valid/out_data/out_qid until out_ready is high.
// IDLE performs the round-robin search and adds one cycle per rotation.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   en         arbitration enable, sampled only in IDLE
//   q_empty    per-queue empty flags (bit i = queue i)
//   q_renable  per-queue read strobe; one-hot or zero; forced low during rst
//   q_rdata    concatenated queue read data; queue i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid  out_data/out_qid valid
//   out_ready  downstream accepts when out_valid && out_ready
//   out_data   captured word
//   out_qid    source queue of out_data
//   busy       high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module fifo_rr_sched #(
  parameter  int NUM_Q      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int BURST_MAX  = 4,
  localparam int QID_WIDTH  = (NUM_Q > 1) ? $clog2(NUM_Q) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic [NUM_Q-1:0]            q_empty,
  output logic [NUM_Q-1:0]            q_renable,
  input  logic [NUM_Q*DATA_WIDTH-1:0] q_rdata,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH-1:0]       out_data,
  output logic [QID_WIDTH-1:0]        out_qid,
  output logic                        busy
);

  // The burst counter must be able to hold the value BURST_MAX itself.
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    LOAD  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t                 state_reg,     state_next;
  logic [QID_WIDTH-1:0]   rr_ptr_reg,    rr_ptr_next;
  logic [QID_WIDTH-1:0]   grant_reg,     grant_next;
  logic [BW-1:0]          burst_cnt_reg, burst_cnt_next;
  logic                   out_valid_reg, out_valid_next;
  logic [DATA_WIDTH-1:0]  out_data_reg,  out_data_next;
  logic [QID_WIDTH-1:0]   out_qid_reg,   out_qid_next;

  // ---------------------------------------------------------------------------
  // Round-robin candidate list. Candidate gi is queue (rr_ptr + gi) mod NUM_Q.
  // The sum has one extra bit so that a single conditional subtract completes
  // the wrap. This keeps the indices below NUM_Q even when NUM_Q is not a power
  // of two.
  // ---------------------------------------------------------------------------
  logic [QID_WIDTH:0]     cand_sum [NUM_Q];
  logic [QID_WIDTH-1:0]   cand_idx [NUM_Q];
  logic [NUM_Q-1:0]       cand_ok;

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_cand
    assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (QID_WIDTH+1)'(gi);
    assign cand_idx[gi] = (cand_sum[gi] >= (QID_WIDTH+1)'(NUM_Q))
                        ? QID_WIDTH'(cand_sum[gi] - (QID_WIDTH+1)'(NUM_Q))
                        : QID_WIDTH'(cand_sum[gi]);
    assign cand_ok[gi]  = ~q_empty[cand_idx[gi]];
  end

  // Select the first non-empty candidate. The loop scans downward so that the
  // lowest offset from rr_ptr is the one that remains.
  logic                   pick_found;
  logic [QID_WIDTH-1:0]   pick_idx;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = NUM_Q - 1; k >= 0; k--) begin
      if (cand_ok[k]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx[k];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-queue read-data slices and read strobes.
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0]  rdata_slice [NUM_Q];

  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_slice
    assign rdata_slice[gi] = q_rdata[gi*DATA_WIDTH +: DATA_WIDTH];
  end

  // The strobe is derived only from the registered grant, which makes it
  // one-hot by construction. Gating it with rst ensures that a reset in ISSUE
  // does not consume a word that would then be discarded.
  for (genvar gi = 0; gi < NUM_Q; gi++) begin : g_ren
    assign q_renable[gi] = ~rst && (state_reg == ISSUE) &&
                           (grant_reg == QID_WIDTH'(gi));
  end

  // ---------------------------------------------------------------------------
  // Burst bookkeeping helpers.
  // ---------------------------------------------------------------------------
  logic [BW-1:0]          burst_inc;
  logic [QID_WIDTH-1:0]   ptr_after_grant;

  assign burst_inc       = burst_cnt_reg + 1'b1;
  assign ptr_after_grant = (grant_reg == QID_WIDTH'(NUM_Q - 1))
                         ? '0 : grant_reg + 1'b1;

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next     = state_reg;
    rr_ptr_next    = rr_ptr_reg;
    grant_next     = grant_reg;
    burst_cnt_next = burst_cnt_reg;
    out_valid_next = out_valid_reg;
    out_data_next  = out_data_reg;
    out_qid_next   = out_qid_reg;

    case (state_reg)
      IDLE: begin
        if (en && pick_found) begin
          grant_next     = pick_idx;
          burst_cnt_next = '0;
          state_next     = ISSUE;
        end
      end

      // This block is the only reader of the queue, and the queue was non-empty
      // when it was granted. The strobe issued in this cycle is therefore
      // always honoured.
      ISSUE: begin
        state_next = LOAD;
      end

      LOAD: begin
        out_data_next  = rdata_slice[grant_reg];
        out_qid_next   = grant_reg;
        out_valid_next = 1'b1;
        state_next     = OUT;
      end

      OUT: begin
        if (out_ready) begin
          out_valid_next = 1'b0;
          burst_cnt_next = burst_inc;
          // Keep the grant only while the burst budget lasts and the queue
          // still holds data. Otherwise hand the search start to the next queue.
          if ((burst_inc < BW'(BURST_MAX)) && !q_empty[grant_reg]) begin
            state_next = ISSUE;
          end else begin
            rr_ptr_next = ptr_after_grant;
            state_next  = IDLE;
          end
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      rr_ptr_reg    <= '0;
      grant_reg     <= '0;
      burst_cnt_reg <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_qid_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      rr_ptr_reg    <= rr_ptr_next;
      grant_reg     <= grant_next;
      burst_cnt_reg <= burst_cnt_next;
      out_valid_reg <= out_valid_next;
      out_data_reg  <= out_data_next;
      out_qid_reg   <= out_qid_next;
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_qid   = out_qid_reg;
  assign busy      = (state_reg != IDLE);

endmodule

// File: tb/tb_fifo_rr_sched.sv
// -----------------------------------------------------------------------------
// tb_fifo_rr_sched
//
// Testbench for fifo_rr_sched with NUM_Q=4, DATA_WIDTH=8 and BURST_MAX=4.
// The bench models the queues as circular buffers with registered rdata.
// Every word expected at the output goes into a scoreboard queue when it is
// loaded. A negedge monitor pops and compares that queue on each handshake.
// Each scenario task also checks cycle timing inline.
// -----------------------------------------------------------------------------
module tb_fifo_rr_sched;

  localparam int NQ    = 4;
  localparam int DW    = 8;
  localparam int QW    = 2;
  localparam int DEPTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [NQ-1:0]    q_empty;
  logic [NQ-1:0]    q_renable;
  logic [NQ*DW-1:0] q_rdata;
  logic             out_valid;
  logic             out_ready;
  logic [DW-1:0]    out_data;
  logic [QW-1:0]    out_qid;
  logic             busy;

  always #5 clk = ~clk;

  fifo_rr_sched #(
    .NUM_Q     (NQ),
    .DATA_WIDTH(DW),
    .BURST_MAX (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .q_empty  (q_empty),
    .q_renable(q_renable),
    .q_rdata  (q_rdata),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_qid  (out_qid),
    .busy     (busy)
  );

  int compared   = 0;
  int mismatched = 0;

  // ---------------- queue models ----------------
  logic [DW-1:0]    qbuf  [NQ][DEPTH];
  int               qwr   [NQ] = '{default: 0};
  int               qrd   [NQ] = '{default: 0};
  logic [DW-1:0]    rdata [NQ] = '{default: '0};
  logic [QW+DW-1:0] exp_q [$];
  logic [QW+DW-1:0] exp_word;

  always @(posedge clk) begin
    for (int i = 0; i < NQ; i++) begin
      if (q_renable[i] && (qwr[i] != qrd[i])) begin
        rdata[i] <= qbuf[i][qrd[i] % DEPTH];
        qrd[i]   <= qrd[i] + 1;
      end
    end
  end

  always_comb begin
    q_empty = '0;
    q_rdata = '0;
    for (int i = 0; i < NQ; i++) begin
      q_empty[i]           = (qwr[i] == qrd[i]);
      q_rdata[i*DW +: DW]  = rdata[i];
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL sb_unexpected: got qid=%0d data=%h, required no output", out_qid, out_data);
      end else begin
        exp_word = exp_q.pop_front();
        if ({out_qid, out_data} !== exp_word) begin
          mismatched++;
          $display("FAIL sb_word: got qid=%0d data=%h, required qid=%0d data=%h",
                   out_qid, out_data, exp_word[DW +: QW], exp_word[DW-1:0]);
        end
      end
      $display("xfer t=%0t qid=%0d data=%h", $time, out_qid, out_data);
    end
    if (q_renable != '0) begin
      compared++;
      if (($countones(q_renable) != 1) || ((q_renable & q_empty) != '0)) begin
        mismatched++;
        $display("FAIL renable_legal: got renable=%b empty=%b, required one-hot to non-empty queue",
                 q_renable, q_empty);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic load_word(input int q, input logic [DW-1:0] d, input bit expect_out);
    qbuf[q][qwr[q] % DEPTH] = d;
    qwr[q] = qwr[q] + 1;
    if (expect_out) exp_q.push_back({QW'(q), d});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain(input int budget, input string name);
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      tick();
      n++;
    end
    compared++;
    if (exp_q.size() != 0 || busy) begin
      mismatched++;
      $display("FAIL %s_drain: got %0d words pending busy=%b, required 0 pending busy=0",
               name, exp_q.size(), busy);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    en = 1'b1;
    out_ready = 1'b1;
    tick();
    sample();
    compared++;
    if (q_renable !== 4'b0000) begin
      mismatched++;
      $display("FAIL rst_renable: got %b required 0000", q_renable);
    end
    compared++;
    if ({out_valid, out_data, out_qid, busy} !== '0) begin
      mismatched++;
      $display("FAIL rst_outputs: got valid=%b data=%h qid=%0d busy=%b required all 0",
               out_valid, out_data, out_qid, busy);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_idle_empty();
    en = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      sample();
      compared++;
      if ({q_renable, out_valid, busy} !== 6'b0) begin
        mismatched++;
        $display("FAIL idle_empty c%0d: got renable=%b valid=%b busy=%b required 0",
                 c, q_renable, out_valid, busy);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_single_queue();
    do_reset();
    load_word(2, 8'hA1, 1'b1);
    load_word(2, 8'hA2, 1'b1);
    out_ready = 1'b1;
    en = 1'b1;                                  // cycle t
    sample();
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL sq_t0_busy: got %b required 0", busy);
    end
    tick(); sample();                           // t+1
    compared++;
    if (q_renable !== 4'b0100) begin
      mismatched++;
      $display("FAIL sq_t1_renable: got %b required 0100", q_renable);
    end
    tick(); sample();                           // t+2
    compared++;
    if ({q_renable, out_valid} !== 5'b0) begin
      mismatched++;
      $display("FAIL sq_t2: got renable=%b valid=%b required 0/0", q_renable, out_valid);
    end
    tick(); sample();                           // t+3
    compared++;
    if ({out_valid, out_qid, out_data} !== {1'b1, 2'd2, 8'hA1}) begin
      mismatched++;
      $display("FAIL sq_t3_out: got v=%b qid=%0d data=%h required 1/2/a1", out_valid, out_qid, out_data);
    end
    tick(); sample();                           // t+4
    compared++;
    if (q_renable !== 4'b0100) begin
      mismatched++;
      $display("FAIL sq_t4_renable: got %b required 0100", q_renable);
    end
    tick(); tick(); sample();                   // t+6
    compared++;
    if ({out_valid, out_qid, out_data} !== {1'b1, 2'd2, 8'hA2}) begin
      mismatched++;
      $display("FAIL sq_t6_out: got v=%b qid=%0d data=%h required 1/2/a2", out_valid, out_qid, out_data);
    end
    tick(); sample();                           // t+7
    compared++;
    if (busy !== 1'b0) begin
      mismatched++;
      $display("FAIL sq_t7_idle: got busy=%b required 0", busy);
    end
    // rr_ptr is now 3, so queue 3 must be served before queue 0.
    tick();
    load_word(0, 8'h10, 1'b0);
    load_word(3, 8'h13, 1'b1);
    exp_q.push_back({2'd0, 8'h10});
    drain(60, "sq");
    en = 1'b0;
  endtask

  task automatic test_bursts();
    int seq [24] = '{0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0,0,1,1,2,2,3,3};
    int sent [NQ] = '{default: 0};
    do_reset();
    for (int q = 0; q < NQ; q++)
      for (int k = 0; k < 6; k++)
        load_word(q, DW'(q * 16 + k), 1'b0);
    for (int i = 0; i < 24; i++) begin
      exp_q.push_back({QW'(seq[i]), DW'(seq[i] * 16 + sent[seq[i]])});
      sent[seq[i]]++;
    end
    out_ready = 1'b1;
    en = 1'b1;
    drain(400, "burst");
    en = 1'b0;
  endtask

  task automatic test_backpressure();
    int pulses = 0;
    int n = 0;
    do_reset();
    load_word(1, 8'h3C, 1'b1);
    out_ready = 1'b0;
    en = 1'b1;
    sample();
    while (!out_valid && n < 10) begin
      if (q_renable != '0) pulses++;
      tick(); sample();
      n++;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL bp_valid_timeout: got valid=%b required 1 within 10 cycles", out_valid);
    end
    for (int c = 0; c < 10; c++) begin
      tick(); sample();
      if (q_renable != '0) pulses++;
      compared++;
      if ({out_valid, out_qid, out_data} !== {1'b1, 2'd1, 8'h3C}) begin
        mismatched++;
        $display("FAIL bp_hold c%0d: got v=%b qid=%0d data=%h required 1/1/3c",
                 c, out_valid, out_qid, out_data);
      end
    end
    tick();
    out_ready = 1'b1;
    sample();
    tick(); sample();
    compared++;
    if ({out_valid, pulses[3:0]} !== {1'b0, 4'd1}) begin
      mismatched++;
      $display("FAIL bp_after: got valid=%b pulses=%0d required 0/1", out_valid, pulses);
    end
    en = 1'b0;
    drain(20, "bp");
  endtask

  task automatic test_reset_midway();
    int n = 0;
    do_reset();
    load_word(1, 8'h51, 1'b0);
    en = 1'b1;                                  // IDLE grants
    tick();
    rst = 1'b1;                                 // ISSUE cycle under reset
    sample();
    compared++;
    if ({q_renable, busy} !== 5'b00001) begin
      mismatched++;
      $display("FAIL rm_issue_rst: got renable=%b busy=%b required 0000/1", q_renable, busy);
    end
    tick();
    rst = 1'b0;
    en = 1'b0;
    sample();
    compared++;
    if ({busy, out_valid, q_empty[1]} !== 3'b000) begin
      mismatched++;
      $display("FAIL rm_issue_after: got busy=%b valid=%b empty1=%b required 0/0/0",
               busy, out_valid, q_empty[1]);
    end
    // rr_ptr restarted at 0, so queue 1 precedes queue 3.
    tick();
    load_word(3, 8'h53, 1'b0);
    exp_q.push_back({2'd1, 8'h51});
    exp_q.push_back({2'd3, 8'h53});
    out_ready = 1'b1;
    en = 1'b1;
    drain(60, "rm1");
    en = 1'b0;

    tick();
    load_word(2, 8'h62, 1'b0);                  // will be discarded
    out_ready = 1'b0;
    en = 1'b1;
    sample();
    while (!out_valid && n < 10) begin
      tick(); sample();
      n++;
    end
    compared++;
    if (out_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL rm_out_timeout: got valid=%b required 1", out_valid);
    end
    tick();
    rst = 1'b1;                                 // OUT cycle under reset
    tick();
    rst = 1'b0;
    en = 1'b0;
    out_ready = 1'b1;
    sample();
    compared++;
    if ({busy, out_valid, q_empty[2]} !== 3'b001) begin
      mismatched++;
      $display("FAIL rm_out_after: got busy=%b valid=%b empty2=%b required 0/0/1",
               busy, out_valid, q_empty[2]);
    end
    tick();
    load_word(3, 8'h73, 1'b0);
    load_word(0, 8'h70, 1'b1);
    exp_q.push_back({2'd3, 8'h73});
    en = 1'b1;
    drain(60, "rm2");
    en = 1'b0;
  endtask

  task automatic test_enable();
    do_reset();
    load_word(1, 8'h9E, 1'b1);
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick(); sample();
      compared++;
      if ({busy, q_renable} !== 5'b0) begin
        mismatched++;
        $display("FAIL en_off c%0d: got busy=%b renable=%b required 0", c, busy, q_renable);
      end
    end
    tick();
    en = 1'b1;                                  // cycle t
    tick(); sample();                           // t+1
    compared++;
    if (q_renable !== 4'b0010) begin
      mismatched++;
      $display("FAIL en_t1_renable: got %b required 0010", q_renable);
    end
    tick(); sample();                           // t+2
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL en_t2_valid: got %b required 0", out_valid);
    end
    tick(); sample();                           // t+3
    compared++;
    if ({out_valid, out_qid} !== {1'b1, 2'd1}) begin
      mismatched++;
      $display("FAIL en_t3_out: got v=%b qid=%0d required 1/1", out_valid, out_qid);
    end
    tick();
    en = 1'b0;                                  // drop en during OUT
    sample();
    tick(); sample();
    compared++;
    if ({out_valid, busy} !== 2'b11) begin
      mismatched++;
      $display("FAIL en_drop_hold: got valid=%b busy=%b required 1/1", out_valid, busy);
    end
    tick();
    out_ready = 1'b1;
    sample();
    tick(); sample();
    compared++;
    if ({out_valid, busy} !== 2'b00) begin
      mismatched++;
      $display("FAIL en_drop_done: got valid=%b busy=%b required 0/0", out_valid, busy);
    end
    drain(20, "en");
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_idle_empty();
    test_single_queue();
    test_bursts();
    test_backpressure();
    test_reset_midway();
    test_enable();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
